// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a UART transmitter.
// Supports ownership locking for back-to-back bytes and a WAIT-state timeout.
module uart_tx_arbiter #(
   parameter int DBIT = 8,
   parameter int TOUT = 200000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req0,
   input  logic            req1,
   input  logic [DBIT-1:0] data0,
   input  logic [DBIT-1:0] data1,
   input  logic            lock0,
   input  logic            lock1,
   input  logic            tx_done_tick,
   output logic            tx_start,
   output logic [DBIT-1:0] d_in,
   output logic            ack0,
   output logic            ack1,
   output logic [1:0]      grant,
   output logic            busy,
   output logic            timeout_err
);

   localparam int TW = $clog2(TOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(TOUT - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]    state;
   logic [TW-1:0] timer;
   logic          last_owner;
   logic          locked;
   logic          owner;
   logic          hold;
   logic          win;

   assign owner = grant[1];

   // A locked owner keeps the bus only while it is still requesting.
   assign hold = locked && (last_owner ? req1 : req0);
   assign win  = hold ? last_owner : ((req0 && req1) ? ~last_owner : req1);

   assign tx_start    = (state == SEND);
   assign busy        = (state != IDLE);
   assign ack0        = (state == DONE) && grant[0];
   assign ack1        = (state == DONE) && grant[1];
   assign timeout_err = (state == WAIT) && (timer == TLAST) && !tx_done_tick;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         timer      <= '0;
         last_owner <= 1'b1;
         locked     <= 1'b0;
         grant      <= '0;
         d_in       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (locked && !hold)
                  locked <= 1'b0;
               if (req0 || req1) begin
                  d_in  <= win ? data1 : data0;
                  grant <= win ? 2'b10 : 2'b01;
                  state <= SEND;
               end
            end
            SEND: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (tx_done_tick) begin
                  state <= DONE;
               end else if (timer == TLAST) begin
                  last_owner <= owner;
                  locked     <= 1'b0;
                  grant      <= '0;
                  timer      <= '0;
                  state      <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            DONE: begin
               last_owner <= owner;
               locked     <= owner ? lock1 : lock0;
               grant      <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester and transmitter models drive
// the DUT while a monitor pops expected start/end events as the DUT shows them.
module tb_uart_tx_arbiter;

   localparam int DBIT = 8;
   localparam int TOUT = 50;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            req0 = 1'b0, req1 = 1'b0;
   logic [DBIT-1:0] data0 = '0, data1 = '0;
   logic            lock0 = 1'b0, lock1 = 1'b0;
   logic            tick_m = 1'b0, tick_s = 1'b0;
   logic            tx_done_tick;
   logic            tx_start;
   logic [DBIT-1:0] d_in;
   logic            ack0, ack1;
   logic [1:0]      grant;
   logic            busy;
   logic            timeout_err;

   assign tx_done_tick = tick_m | tick_s;

   uart_tx_arbiter #(.DBIT(DBIT), .TOUT(TOUT)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .data0(data0), .data1(data1),
      .lock0(lock0), .lock1(lock1), .tx_done_tick(tx_done_tick),
      .tx_start(tx_start), .d_in(d_in), .ack0(ack0), .ack1(ack1),
      .grant(grant), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } byte_t;

   typedef struct {
      int         kind;
      logic [7:0] d;
      logic [1:0] g;
      logic [2:0] ev;
      int         lat;
   } exp_t;

   byte_t rq0_q[$];
   byte_t rq1_q[$];
   int    dly_q[$];
   exp_t  exp_q[$];

   int n_pass = 0;
   int n_checks = 0;
   int last_start = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, want);
   endtask

   task automatic exp_start(input logic [7:0] d, input logic [1:0] g, input int at);
      exp_t e;
      e.kind = 0; e.d = d; e.g = g; e.ev = 3'b000; e.lat = at;
      exp_q.push_back(e);
   endtask

   task automatic exp_end(input logic [2:0] ev, input logic [7:0] d, input logic [1:0] g, input int lat);
      exp_t e;
      e.kind = 1; e.d = d; e.g = g; e.ev = ev; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic send(input int which, input logic [7:0] d, input logic l);
      byte_t b;
      b.d = d; b.l = l;
      if (which == 0) rq0_q.push_back(b);
      else rq1_q.push_back(b);
   endtask

   task automatic check_zero(input string name);
      check({name, "_tx_start"}, tx_start, 0);
      check({name, "_ack0"}, ack0, 0);
      check({name, "_ack1"}, ack1, 0);
      check({name, "_timeout_err"}, timeout_err, 0);
      check({name, "_busy"}, busy, 0);
      check({name, "_grant"}, grant, 0);
      check({name, "_d_in"}, d_in, 0);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (n < 1000 && (exp_q.size() != 0 || busy || rq0_q.size() != 0 || rq1_q.size() != 0)) begin
         @(negedge clk);
         n++;
      end
      check({name, "_completed"}, (n < 1000), 1);
      check({name, "_grant_idle"}, grant, 0);
   endtask

   // Requesters hold req/data/lock through their ack and advance the cycle after it.
   initial forever begin
      logic a;
      @(negedge clk);
      a = ack0;
      @(posedge clk);
      #1;
      if (a && rq0_q.size() > 0) void'(rq0_q.pop_front());
      if (rq0_q.size() > 0) begin
         req0 = 1'b1; data0 = rq0_q[0].d; lock0 = rq0_q[0].l;
      end else begin
         req0 = 1'b0; lock0 = 1'b0;
      end
   end

   initial forever begin
      logic a;
      @(negedge clk);
      a = ack1;
      @(posedge clk);
      #1;
      if (a && rq1_q.size() > 0) void'(rq1_q.pop_front());
      if (rq1_q.size() > 0) begin
         req1 = 1'b1; data1 = rq1_q[0].d; lock1 = rq1_q[0].l;
      end else begin
         req1 = 1'b0; lock1 = 1'b0;
      end
   end

   // Transmitter model: tick d cycles after tx_start; negative delay means never.
   initial forever begin
      int d;
      @(negedge clk);
      if (tx_start) begin
         if (dly_q.size() > 0) d = dly_q.pop_front();
         else d = -1;
         if (d >= 0) begin
            repeat (d) @(posedge clk);
            #1 tick_m = 1'b1;
            @(posedge clk);
            #1 tick_m = 1'b0;
         end
      end
   end

   initial forever begin
      exp_t       e;
      logic [2:0] ev;
      @(negedge clk);
      if (tx_start) begin
         if (exp_q.size() == 0) begin
            check("unexpected_start", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("start_order", e.kind, 0);
            check("start_d_in", d_in, e.d);
            check("start_grant", grant, e.g);
            if (e.lat >= 0) check("start_cycle", cyc, e.lat);
         end
         last_start = cyc;
      end
      ev = {timeout_err, ack1, ack0};
      if (ev != 3'b000) begin
         if (exp_q.size() == 0) begin
            check("unexpected_end", ev, 0);
         end else begin
            e = exp_q.pop_front();
            check("end_order", e.kind, 1);
            check("end_event", ev, e.ev);
            check("end_d_in", d_in, e.d);
            check("end_grant", grant, e.g);
            check("end_latency", cyc - last_start, e.lat);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_zero("por");
      reset = 1'b1;

      // Tick in IDLE is ignored.
      @(negedge clk); tick_s = 1'b1;
      @(negedge clk); tick_s = 1'b0;
      @(negedge clk);
      check("idle_tick_busy", busy, 0);

      // Single request; requester data changes after latch must not reach d_in.
      dly_q.push_back(20);
      exp_start(8'h41, 2'b01, cyc + 2);
      exp_end(3'b001, 8'h41, 2'b01, 21);
      send(0, 8'h41, 1'b0);
      repeat (6) @(negedge clk);
      begin
         byte_t b;
         b = rq0_q[0]; b.d = 8'hEE; rq0_q[0] = b;
      end
      wait_idle("single");

      // Tie right after reset, then a second tie.
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      repeat (4) dly_q.push_back(5);
      exp_start(8'h30, 2'b01, cyc + 2);
      exp_end(3'b001, 8'h30, 2'b01, 6);
      exp_start(8'h31, 2'b10, -1);
      exp_end(3'b010, 8'h31, 2'b10, 6);
      send(0, 8'h30, 1'b0);
      send(1, 8'h31, 1'b0);
      wait_idle("tie1");
      exp_start(8'h32, 2'b01, cyc + 2);
      exp_end(3'b001, 8'h32, 2'b01, 6);
      exp_start(8'h33, 2'b10, -1);
      exp_end(3'b010, 8'h33, 2'b10, 6);
      send(0, 8'h32, 1'b0);
      send(1, 8'h33, 1'b0);
      wait_idle("tie2");

      // Lock: req1 wins a tie then keeps the bus for three bytes.
      dly_q.push_back(5);
      exp_start(8'h34, 2'b01, cyc + 2);
      exp_end(3'b001, 8'h34, 2'b01, 6);
      send(0, 8'h34, 1'b0);
      wait_idle("lock_prep");
      repeat (4) dly_q.push_back(5);
      exp_start(8'hA1, 2'b10, cyc + 2);
      exp_end(3'b010, 8'hA1, 2'b10, 6);
      exp_start(8'hA2, 2'b10, -1);
      exp_end(3'b010, 8'hA2, 2'b10, 6);
      exp_start(8'hA3, 2'b10, -1);
      exp_end(3'b010, 8'hA3, 2'b10, 6);
      exp_start(8'h40, 2'b01, -1);
      exp_end(3'b001, 8'h40, 2'b01, 6);
      send(1, 8'hA1, 1'b1);
      send(1, 8'hA2, 1'b1);
      send(1, 8'hA3, 1'b1);
      send(0, 8'h40, 1'b0);
      wait_idle("lock");

      // Timeout with no tick; the following tie goes to the other requester.
      dly_q.push_back(-1);
      dly_q.push_back(5);
      dly_q.push_back(5);
      exp_start(8'h50, 2'b01, cyc + 2);
      exp_end(3'b100, 8'h50, 2'b01, TOUT);
      exp_start(8'h51, 2'b10, -1);
      exp_end(3'b010, 8'h51, 2'b10, 6);
      exp_start(8'h50, 2'b01, -1);
      exp_end(3'b001, 8'h50, 2'b01, 6);
      send(0, 8'h50, 1'b0);
      repeat (10) @(negedge clk);
      send(1, 8'h51, 1'b0);
      wait_idle("timeout");

      // Tick in the same cycle as the timeout: ack wins.
      dly_q.push_back(TOUT);
      exp_start(8'h60, 2'b10, cyc + 2);
      exp_end(3'b010, 8'h60, 2'b10, TOUT + 1);
      send(1, 8'h60, 1'b0);
      wait_idle("simultaneous");

      // Reset during WAIT abandons the byte; a new request is served afterwards.
      dly_q.push_back(-1);
      exp_start(8'h70, 2'b01, cyc + 2);
      send(0, 8'h70, 1'b0);
      repeat (10) @(negedge clk);
      check("wait_busy", busy, 1);
      #2 reset = 1'b0;
      rq0_q.delete();
      #1 check_zero("rst_wait");
      check("rst_start_seen", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      dly_q.push_back(5);
      exp_start(8'h71, 2'b10, cyc + 2);
      exp_end(3'b010, 8'h71, 2'b10, 6);
      send(1, 8'h71, 1'b0);
      wait_idle("after_reset");

      repeat (5) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DBIT, default 8, data bits per byte.
REQ-002 Parameter TOUT, default 200000, clk cycles allowed in WAIT before a transfer is abandoned.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req0, req1  in  1 each  requester n has a byte pending; held high until its ack.
REQ-006 data0, data1  in  DBIT each  byte from requester n; stable while its req is high.
REQ-007 lock0, lock1  in  1 each  requester n keeps ownership for back-to-back bytes.
REQ-008 tx_done_tick  in  1  one-cycle pulse from the UART transmitter when a byte is finished.
REQ-009 tx_start  out  1  one-cycle start pulse to the UART transmitter.
REQ-010 d_in  out  DBIT  registered byte to the UART transmitter.
REQ-011 ack0, ack1  out  1 each  one-cycle pulse when requester n's byte has been sent.
REQ-012 grant  out  2  one-hot current owner; 2'b00 when no owner.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 timeout_err  out  1  one-cycle pulse when a transfer is abandoned.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SEND, WAIT and DONE.
REQ-016 IDLE: with no req high, the FSM SHALL stay in IDLE with grant=00.
- If any req is high, it SHALL select a winner, latch that requester's data into d_in, set grant, and go to SEND on the next edge.
REQ-017 Arbitration SHALL be round-robin on register last_owner (reset value 1).
- On a tie, the requester that is not last_owner wins.
- A lone requester always wins.
REQ-018 If the locked flag is set and the previous owner's req is high in IDLE, that owner SHALL win regardless of the other req.
- If the locked flag is set and the previous owner's req is low, the FSM SHALL clear the flag and arbitrate normally in the same cycle.
REQ-019 SEND: tx_start SHALL be 1 for exactly this one cycle; the FSM SHALL then go to WAIT.
- Latency: a req sampled in IDLE at cycle N gives tx_start=1 at cycle N+1.
REQ-020 WAIT: tx_start SHALL be 0 and a timer SHALL count from 0 each clk.
- tx_done_tick=1 SHALL cause a transition to DONE.
REQ-021 DONE: for exactly one cycle the FSM SHALL:
- pulse ack of the owner only;
- set last_owner to the owner;
- set the locked flag to the owner's lock value;
- clear grant;
- return to IDLE.
REQ-022 If the timer reaches TOUT-1 in WAIT without tx_done_tick, the FSM SHALL:
- pulse timeout_err for one cycle;
- issue no ack;
- set last_owner to the owner and clear the locked flag;
- clear grant;
- return to IDLE.
REQ-023 If tx_done_tick and the timeout occur in the same cycle, tx_done_tick SHALL take priority: DONE path, no timeout_err.
REQ-024 tx_done_tick received in IDLE, SEND or DONE SHALL be ignored.
REQ-025 d_in SHALL hold its latched value until the next latch in IDLE.
REQ-026 Requester data or req changes after the latch SHALL NOT affect d_in.
REQ-027 A requester that drops req before its ack SHALL still have its byte sent and acked; no abort path exists.
REQ-028 The timer SHALL be wide enough for TOUT and SHALL saturate, never wrap.
REQ-029 At most one of ack0, ack1 or timeout_err SHALL be high in any cycle.

Reset
REQ-030 reset low SHALL immediately, independent of clk, force:
- state IDLE;
- tx_start, ack0, ack1, timeout_err, busy = 0;
- grant = 00, d_in = 0;
- timer = 0, last_owner = 1, locked flag = 0.
REQ-031 Reset asserted in SEND or WAIT SHALL abandon the transfer with no ack and no timeout_err.
- After reset is released, arbitration SHALL restart from IDLE.

Verification
REQ-032 Single request: req0=1, data0=8'h41, tx_done_tick 20 cycles after tx_start
- tx_start one cycle after req0;
- d_in=8'h41;
- ack0 pulses one cycle after tx_done_tick;
- grant returns to 00.
REQ-033 Tie after reset: req0=req1=1 with data 8'h30 and 8'h31
- order sent is 8'h30 then 8'h31;
- a second tie then grants req0 (last_owner=1).
REQ-034 Lock: lock1=1 and req1 held for three bytes while req0=1
- all three req1 bytes are sent before req0;
- ack1 pulses three times, then ack0 once.
REQ-035 Timeout with TOUT=50: no tx_done_tick after tx_start
- timeout_err pulses 50 cycles into WAIT;
- no ack;
- next tie is granted to the other requester.
REQ-036 Reset during WAIT
- all outputs are 0 immediately;
- the pending byte is not acked;
- a new req is served normally after reset is released.
REQ-037 Simultaneous tx_done_tick and timeout
- ack pulses;
- timeout_err stays 0.
